// File: rtl/transfer_hold_buffer_pkg.sv
// ============================================================================
// Module      : transfer_hold_buffer_pkg
// Description : Shared definitions for the transfer hold buffer: default
//               sizing and the buffer occupancy state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package transfer_hold_buffer_pkg;

    // Default sizing for the buffer
    localparam int TH_DEF_WIDTH = 8;
    localparam int TH_DEF_CNT_W = 8;

    // Occupancy states: number of words currently held
    typedef enum logic [1:0] {
        TH_EMPTY = 2'd0,
        TH_ONE   = 2'd1,
        TH_TWO   = 2'd2
    } th_state_e;

endpackage : transfer_hold_buffer_pkg

`default_nettype wire

// File: rtl/transfer_hold_buffer_or.sv
// ============================================================================
// Module      : transfer_or_1bit / transfer_or_nbit
// Description : OR-based transfer gate. next = (sel & new) | (~sel & hold).
//               The n-bit version replicates the 1-bit gate per bit and
//               shares a single select.
// Ports       : sel_i  - 1 loads new_i, 0 passes hold_i through
//               new_i  - incoming word
//               hold_i - current register value fed back
//               next_o - value to load into the register
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module transfer_or_1bit (
    input  logic sel_i,
    input  logic new_i,
    input  logic hold_i,
    output logic next_o
);

    // AND-OR form: with sel_i=0 an unknown new_i is masked to 0
    assign next_o = (sel_i & new_i) | (~sel_i & hold_i);

endmodule : transfer_or_1bit

module transfer_or_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] new_i,
    input  logic [WIDTH-1:0] hold_i,
    output logic [WIDTH-1:0] next_o
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        transfer_or_1bit u_gate (
            .sel_i  (sel_i),
            .new_i  (new_i[gi]),
            .hold_i (hold_i[gi]),
            .next_o (next_o[gi])
        );
    end : g_bit

endmodule : transfer_or_nbit

`default_nettype wire

// File: rtl/transfer_hold_buffer.sv
// ============================================================================
// Module      : transfer_hold_buffer
// Description : Two-entry skid buffer between a valid/ready producer and
//               consumer. Full throughput, ready decoded from registered
//               state only. Storage registers reload exclusively through
//               OR-based transfer gates (no register enables).
// Ports       : clk, rst_n (async, active low)
//               in_valid/in_ready/in_data    - producer side
//               out_valid/out_ready/out_data - consumer side
//               xfer_count                   - delivered words mod 2^CNT_W
//               out_parity                   - XOR of out_data (optional)
// Config      : TRANSFER_HOLD_PARITY_EN - adds out_parity and parity storage
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module transfer_hold_buffer
    import transfer_hold_buffer_pkg::*;
#(
    parameter int WIDTH = TH_DEF_WIDTH,
    parameter int CNT_W = TH_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] xfer_count
`ifdef TRANSFER_HOLD_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    th_state_e        state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [WIDTH-1:0] main_new;
    logic [CNT_W-1:0] cnt_q;

    logic main_sel;
    logic skid_sel;
    logic main_from_skid;
    logic in_fire;
    logic out_fire;

    // Handshake flags come from registered state only
    assign in_ready  = (state_q != TH_TWO);
    assign out_valid = (state_q != TH_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Next-state and transfer-gate select decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        main_sel       = 1'b0;
        skid_sel       = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            TH_EMPTY: begin
                if (in_fire) begin
                    main_sel = 1'b1;
                    state_d  = TH_ONE;
                end
            end
            TH_ONE: begin
                if (in_fire && out_fire) begin
                    main_sel = 1'b1;
                end else if (in_fire) begin
                    skid_sel = 1'b1;
                    state_d  = TH_TWO;
                end else if (out_fire) begin
                    // main keeps its stale word; out_valid masks it
                    state_d  = TH_EMPTY;
                end
            end
            TH_TWO: begin
                if (out_fire) begin
                    main_sel       = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = TH_ONE;
                end
            end
            default: begin
                state_d = TH_EMPTY;
            end
        endcase
    end

    assign main_new = main_from_skid ? skid_q : in_data;

    transfer_or_nbit #(.WIDTH(WIDTH)) u_main_gate (
        .sel_i  (main_sel),
        .new_i  (main_new),
        .hold_i (main_q),
        .next_o (main_d)
    );

    transfer_or_nbit #(.WIDTH(WIDTH)) u_skid_gate (
        .sel_i  (skid_sel),
        .new_i  (in_data),
        .hold_i (skid_q),
        .next_o (skid_d)
    );

    // Registers load the gate output every cycle; the gate does the holding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TH_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_q + CNT_W'(out_fire);
        end
    end

    assign out_data   = main_q;
    assign xfer_count = cnt_q;

`ifdef TRANSFER_HOLD_PARITY_EN
    // Parity is captured with the word and travels alongside it
    logic [0:0] par_main_q, par_main_d;
    logic [0:0] par_skid_q, par_skid_d;
    logic [0:0] par_in;
    logic [0:0] par_main_new;

    assign par_in       = ^in_data;
    assign par_main_new = main_from_skid ? par_skid_q : par_in;

    transfer_or_nbit #(.WIDTH(1)) u_par_main_gate (
        .sel_i  (main_sel),
        .new_i  (par_main_new),
        .hold_i (par_main_q),
        .next_o (par_main_d)
    );

    transfer_or_nbit #(.WIDTH(1)) u_par_skid_gate (
        .sel_i  (skid_sel),
        .new_i  (par_in),
        .hold_i (par_skid_q),
        .next_o (par_skid_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_main_q <= '0;
            par_skid_q <= '0;
        end else begin
            par_main_q <= par_main_d;
            par_skid_q <= par_skid_d;
        end
    end

    assign out_parity = par_main_q[0];
`endif

endmodule : transfer_hold_buffer

`default_nettype wire

// File: doc/transfer_hold_buffer.md
Name: transfer_hold_buffer

Overview:
- Two-entry skid buffer that sits directly downstream of the OR-based transfer gates.
- Each storage register reloads through a per-bit transfer gate: next = (sel & new) | (~sel & hold). The gate's select comes from this block's FSM and its hold input is fed back from the register.
- Decouples a producer from a consumer with valid/ready on both sides, at full throughput and with no combinational ready path.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- CNT_W, 8, width of the delivered-word counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a word on in_data.
- in_ready  out  1  buffer can accept a word this cycle.
- in_data  in  WIDTH  producer word.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  WIDTH  oldest buffered word.
- xfer_count  out  CNT_W  number of out-side transfers since reset, modulo 2^CNT_W.

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main_reg (drives out_data) and skid_reg.
  - Each register is loaded only via transfer gates. sel=1 loads the new word; sel=0 holds via feedback. No other register enable is used.
- FSM states: EMPTY (0 words), ONE (main valid), TWO (main and skid valid).
- in_ready = (state != TWO). out_valid = (state != EMPTY). Both are decoded from registered state only, with no input-to-output combinational path.
- Transitions:
  - EMPTY:
    - in_fire -> main<=in_data, go to ONE.
    - Otherwise stay in EMPTY.
  - ONE:
    - in_fire & out_fire -> main<=in_data, stay in ONE.
    - in_fire only -> skid<=in_data, go to TWO.
    - out_fire only -> go to EMPTY, main holds its old value.
    - Neither -> hold.
  - TWO:
    - out_fire -> main<=skid, go to ONE. in_valid is ignored because in_ready=0.
    - Otherwise hold.
- Latency: a word accepted in cycle N is on out_data with out_valid=1 in cycle N+1 if the buffer was EMPTY.
- Throughput: 1 word/cycle sustained when out_ready is held at 1.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_data must not change.
- xfer_count increments by 1 on each out_fire and wraps from 2^CNT_W-1 to 0.
- Reset: asserting rst_n=0 at any time, including mid-transfer, immediately forces:
  - state=EMPTY, main_reg=0, skid_reg=0, xfer_count=0.
  - out_valid=0, in_ready=1, out_data=0.
  - Buffered words are discarded.
- X on in_data while in_valid=0 must never propagate into the registers.

Optional Feature:
- TRANSFER_HOLD_PARITY_EN defined:
  - Adds output port out_parity (1 bit), the even parity (XOR reduction) of the word at out_data.
  - Parity is computed at capture time and stored beside main/skid through its own transfer gate. It moves with the data from skid to main.
  - Reset value is 0.
- Not defined: the port, storage and logic are absent. All other behaviour is identical.

Decomposition:
- Shared include file transfer_defs.vh holds:
  - State encoding localparams: TH_EMPTY=2'd0, TH_ONE=2'd1, TH_TWO=2'd2.
  - Default WIDTH and CNT_W values.
- Sub-module transfer_or_nbit (WIDTH-parameterised) instantiates one transfer_or_1bit per bit via generate. It is used once for main_reg (new word muxed from in_data or skid_reg) and once for skid_reg.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high with in_valid=0 -> out_valid=0, in_ready=1, xfer_count=0, out_data=0.
- Single word: in_data=8'hA5 with in_valid for 1 cycle, out_ready=1 -> next cycle out_valid=1 and out_data=A5; one cycle after that out_valid=0 and xfer_count=1.
- Backpressure: out_ready=0, push 8'h11 then 8'h22 -> in_ready drops to 0 after the second; 8'h33 is held off. Raise out_ready -> outputs 11, 22, 33 in order, out_data stable during the stall.
- Streaming: in_valid=out_ready=1 for 300 cycles with an incrementing pattern -> one word per cycle, no gaps, xfer_count wraps 255->0 and ends at 300 mod 256 = 44.
- Reset mid-operation: buffer in TWO holding 8'hC3 and 8'h3C, assert rst_n=0 -> same cycle out_valid=0, in_ready=1, xfer_count=0. After release, the old words never appear.
- With TRANSFER_HOLD_PARITY_EN: push 8'h07 then 8'h03 -> out_parity=1 then 0, aligned with each word.
